bus_fabric: RTL

Parametrised single-master bus fabric that sits between the core and `SLV_CNT` peripheral controllers. It decodes each request against per-slave base/mask pairs, tracks the one outstanding transaction, and steers the selected slave's response and read data back to the master. Decode errors, slave faults, master faults and protocol violations are collected into a sticky fault latch with cause and address capture; an optional watchdog also flags slaves that never respond. Once the latch is set, all further bus responses are suppressed until reset.

---
 rtl/bus_fabric.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_fabric.sv
// Single-master bus fabric: base/mask decode, one outstanding transaction, sticky fault latch.
// Optional wait-state watchdog enabled by defining BUS_FABRIC_TIMEOUT_EN.
module bus_fabric #(
    parameter int                    SLV_CNT  = 6,
    parameter int                    AW       = 32,
    parameter int                    DW       = 32,
    parameter int                    ACCW     = 2,
    parameter logic [SLV_CNT*AW-1:0] SLV_BASE = '0,
    parameter logic [SLV_CNT*AW-1:0] SLV_MASK = '0,
    parameter int                    TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         m_addr,
    input  logic                  m_w_rb,
    input  logic [ACCW-1:0]       m_acc,
    input  logic [DW-1:0]         m_wdata,
    input  logic                  m_req,
    input  logic                  m_fault,
    output logic [DW-1:0]         m_rdata,
    output logic                  m_resp,
    output logic [AW-1:0]         s_addr,
    output logic                  s_w_rb,
    output logic [ACCW-1:0]       s_acc,
    output logic [DW-1:0]         s_wdata,
    output logic [SLV_CNT-1:0]    s_req,
    input  logic [SLV_CNT-1:0]    s_resp,
    input  logic [SLV_CNT*DW-1:0] s_rdata,
    input  logic [SLV_CNT-1:0]    s_fault,
    output logic                  fault,
    output logic [2:0]            fault_cause,
    output logic [AW-1:0]         fault_addr
);

    localparam int SW = (SLV_CNT > 1) ? $clog2(SLV_CNT) : 1;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_DECODE   = 3'd1;
    localparam logic [2:0] C_SLAVE    = 3'd2;
    localparam logic [2:0] C_TIMEOUT  = 3'd3;
    localparam logic [2:0] C_MASTER   = 3'd4;
    localparam logic [2:0] C_PROTOCOL = 3'd5;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    generate
        if (SLV_CNT < 1 || SLV_CNT > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
            $error("bus_fabric: SLV_CNT or TIMEOUT out of range");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            fault_q, fault_d;
    logic [2:0]      cause_q, cause_d;
    logic [AW-1:0]   faddr_q, faddr_d;

    logic [SLV_CNT-1:0] hit;
    logic [SLV_CNT-1:0] sel_oh;
    logic [SW-1:0]      sel_idx;
    logic               any_hit;
    logic               start;
    logic               in_wait;
    logic [SW-1:0]      act_idx;
    logic               act_resp;
    logic               act_sfault;
    logic               timeout_hit;
    logic [2:0]         det_cause;
    logic [AW-1:0]      det_addr;
    logic               det;

    genvar gi;
    generate
        for (gi = 0; gi < SLV_CNT; gi++) begin : g_dec
            assign hit[gi] = (m_addr & SLV_MASK[gi*AW +: AW]) == SLV_BASE[gi*AW +: AW];
        end
    endgenerate

    // Lowest-indexed matching slave wins on overlapping windows.
    always_comb begin
        sel_idx = '0;
        any_hit = 1'b0;
        for (int i = SLV_CNT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_idx = SW'(i);
                any_hit = 1'b1;
            end
        end
        sel_oh = '0;
        if (any_hit) begin
            sel_oh[sel_idx] = 1'b1;
        end
    end

    assign in_wait    = (state_q == S_WAIT) && !fault_q;
    assign start      = (state_q == S_IDLE) && m_req && any_hit && !fault_q;
    assign act_idx    = in_wait ? sel_q : sel_idx;
    assign act_resp   = (start || in_wait) && s_resp[act_idx];
    assign act_sfault = (start || in_wait) && s_fault[act_idx];

`ifdef BUS_FABRIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (in_wait && cnt_q != CW'(TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q holds completed wait cycles, so this is the TIMEOUT-th wait cycle.
    assign timeout_hit = in_wait && (cnt_q == CW'(TIMEOUT - 1)) && !s_resp[sel_q];
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        det_cause = C_NONE;
        det_addr  = m_addr;
        if (!fault_q) begin
            if (m_fault) begin
                det_cause = C_MASTER;
            end else if (m_req && in_wait) begin
                det_cause = C_PROTOCOL;
            end else if (act_sfault) begin
                det_cause = C_SLAVE;
                det_addr  = in_wait ? addr_q : m_addr;
            end else if (m_req && !any_hit) begin
                det_cause = C_DECODE;
            end else if (timeout_hit) begin
                det_cause = C_TIMEOUT;
                det_addr  = addr_q;
            end
        end
    end

    assign det = (det_cause != C_NONE);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        fault_d = fault_q | det;
        cause_d = det ? det_cause : cause_q;
        faddr_d = det ? det_addr : faddr_q;
        if (fault_q || det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !s_resp[sel_idx]) begin
                        state_d = S_WAIT;
                        sel_d   = sel_idx;
                        addr_d  = m_addr;
                    end
                end
                S_WAIT: begin
                    if (s_resp[sel_q]) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            fault_q <= 1'b0;
            cause_q <= C_NONE;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            faddr_q <= faddr_d;
        end
    end

    // Reset also gates the combinational paths so requests drop without waiting for an edge.
    assign s_req   = (start && !rst) ? sel_oh : '0;
    assign m_resp  = act_resp && !act_sfault && !det && !rst;
    assign m_rdata = s_rdata[act_idx*DW +: DW];

    assign s_addr  = m_addr;
    assign s_w_rb  = m_w_rb;
    assign s_acc   = m_acc;
    assign s_wdata = m_wdata;

    assign fault       = fault_q;
    assign fault_cause = cause_q;
    assign fault_addr  = faddr_q;

endmodule
